// File: rtl/ps2_event_arbiter_pkg.sv
// Shared constants for the PS2 event arbiter: button codes, player ids and
// output-slot state encoding.
package ps2_pkg;

  localparam int unsigned NBTN = 10;

  localparam logic [3:0] BTN_CIRCLE   = 4'd1;
  localparam logic [3:0] BTN_CROSS    = 4'd2;
  localparam logic [3:0] BTN_SQUARE   = 4'd3;
  localparam logic [3:0] BTN_TRIANGLE = 4'd4;
  localparam logic [3:0] BTN_LEFT     = 4'd5;
  localparam logic [3:0] BTN_RIGHT    = 4'd6;
  localparam logic [3:0] BTN_UP       = 4'd7;
  localparam logic [3:0] BTN_DOWN     = 4'd8;
  localparam logic [3:0] BTN_R1       = 4'd9;
  localparam logic [3:0] BTN_START    = 4'd10;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/ps2_event_arbiter_if.sv
// Valid/ready event channel from the arbiter (master) to the game logic (slave).
interface ps2_event_arbiter_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_player;
  logic [3:0] ev_button;

  modport master (output ev_valid, output ev_player, output ev_button, input ev_ready);
  modport slave  (input ev_valid, input ev_player, input ev_button, output ev_ready);
endinterface

// File: rtl/ps2_event_arbiter_pending_bank.sv
// Per-player edge detector and pending-press register; optional auto-repeat
// hold counter when PS2_EVENT_REPEAT_EN is defined.
module ps2_pending_bank
  import ps2_pkg::*;
#(
  parameter int unsigned NBTN = ps2_pkg::NBTN
`ifdef PS2_EVENT_REPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = 25000000
  , parameter int unsigned REPEAT_PERIOD = 5000000
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NBTN-1:0]             c_i,
  input  logic [NBTN-1:0]             grant_mask_i,
  output logic [NBTN-1:0]             pend_o,
  output logic [$clog2(NBTN+1)-1:0]   drop_o
);

  localparam int unsigned DROP_W = $clog2(NBTN + 1);

  function automatic logic [DROP_W-1:0] popcount(input logic [NBTN-1:0] v);
    logic [DROP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NBTN; i++) begin
      n = n + DROP_W'(v[i]);
    end
    return n;
  endfunction

  logic [NBTN-1:0] c_q;
  logic [NBTN-1:0] pend_q, pend_d;
  logic [NBTN-1:0] rise_s, keep_s, rep_set_s;

  assign rise_s = c_i & ~c_q;
  assign keep_s = pend_q & ~grant_mask_i;

`ifdef PS2_EVENT_REPEAT_EN
  logic [24:0] hold_q, hold_d;

  // Hold counter: restarts on any level change, counts while held, reloads after each repeat
  always_comb begin
    hold_d    = hold_q;
    rep_set_s = '0;
    if (flush || (c_i != c_q) || (c_i == '0)) begin
      hold_d = 25'd0;
    end else if (hold_q == 25'(REPEAT_DELAY - 1)) begin
      hold_d    = 25'(REPEAT_DELAY - REPEAT_PERIOD);
      rep_set_s = c_i;
    end else begin
      hold_d = hold_q + 25'd1;
    end
  end

  // Hold counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q <= 25'd0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign rep_set_s = '0;
`endif

  // Next pending set: flush wins, otherwise a new rise beats the grant clear
  always_comb begin
    if (flush) begin
      pend_d = '0;
    end else begin
      pend_d = keep_s | rise_s | rep_set_s;
    end
  end

  // Level history and pending register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_q    <= '0;
      pend_q <= '0;
    end else begin
      c_q    <= c_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;
  assign drop_o = flush ? '0 : popcount(rise_s & keep_s);

endmodule

// File: rtl/ps2_event_arbiter.sv
// Turns two players' button levels into a round-robin stream of press events.
// Build option: PS2_EVENT_REPEAT_EN enables hold-to-repeat.
module ps2_event_arbiter
  import ps2_pkg::*;
#(
  parameter int unsigned NBTN = ps2_pkg::NBTN
`ifdef PS2_EVENT_REPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = 25000000
  , parameter int unsigned REPEAT_PERIOD = 5000000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NBTN-1:0]     c1,
  input  logic [NBTN-1:0]     c2,
  input  logic                flush,
  ps2_event_arbiter_if.master ev,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned DROP_W = $clog2(NBTN + 1);

  function automatic logic [3:0] lowest_code(input logic [NBTN-1:0] v);
    logic [3:0] code;
    code = 4'd0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (v[i]) begin
        code = 4'(i + 1);
      end
    end
    return code;
  endfunction

  logic [NBTN-1:0]   pend1_s, pend2_s, grant1_s, grant2_s, sel_pend_s, onehot_s;
  logic [DROP_W-1:0] drop1_s, drop2_s;
  logic              any1_s, any2_s, sel_player_s, load_s;
  logic [3:0]        code_s;
  logic [8:0]        drop_sum_s;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  slot_state_e       state_q;
  logic              ev_player_q, rr_last_q;
  logic [3:0]        ev_button_q;

`ifdef PS2_EVENT_REPEAT_EN
  ps2_pending_bank #(.NBTN(NBTN), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_bank1 (
`else
  ps2_pending_bank #(.NBTN(NBTN)) u_bank1 (
`endif
    .clock(clock), .reset(reset), .flush(flush), .c_i(c1),
    .grant_mask_i(grant1_s), .pend_o(pend1_s), .drop_o(drop1_s)
  );

`ifdef PS2_EVENT_REPEAT_EN
  ps2_pending_bank #(.NBTN(NBTN), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_bank2 (
`else
  ps2_pending_bank #(.NBTN(NBTN)) u_bank2 (
`endif
    .clock(clock), .reset(reset), .flush(flush), .c_i(c2),
    .grant_mask_i(grant2_s), .pend_o(pend2_s), .drop_o(drop2_s)
  );

  assign any1_s = |pend1_s;
  assign any2_s = |pend2_s;

  // Player pick: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    if (any1_s && any2_s) begin
      sel_player_s = ~rr_last_q;
    end else if (any2_s) begin
      sel_player_s = PLAYER2;
    end else begin
      sel_player_s = PLAYER1;
    end
  end

  assign sel_pend_s = (sel_player_s == PLAYER2) ? pend2_s : pend1_s;
  assign code_s     = lowest_code(sel_pend_s);
  assign load_s     = !flush && ((state_q == SLOT_EMPTY) || ev.ev_ready) && (any1_s || any2_s);

  // One-hot of the granted button
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < NBTN; i++) begin
      onehot_s[i] = (code_s == 4'(i + 1));
    end
  end

  assign grant1_s = (load_s && (sel_player_s == PLAYER1)) ? onehot_s : '0;
  assign grant2_s = (load_s && (sel_player_s == PLAYER2)) ? onehot_s : '0;

  // Output slot FSM with registered event fields and round-robin memory
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= SLOT_EMPTY;
      ev_player_q <= 1'b0;
      ev_button_q <= 4'd0;
      rr_last_q   <= PLAYER2;
    end else if (flush) begin
      state_q <= SLOT_EMPTY;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (load_s) begin
            state_q     <= SLOT_FULL;
            ev_player_q <= sel_player_s;
            ev_button_q <= code_s;
            rr_last_q   <= sel_player_s;
          end
        end
        SLOT_FULL: begin
          if (load_s) begin
            ev_player_q <= sel_player_s;
            ev_button_q <= code_s;
            rr_last_q   <= sel_player_s;
          end else if (ev.ev_ready) begin
            state_q <= SLOT_EMPTY;
          end
        end
        default: begin
          state_q <= SLOT_EMPTY;
        end
      endcase
    end
  end

  assign drop_sum_s = 9'(drop_cnt_q) + 9'(drop1_s) + 9'(drop2_s);

  // Saturating coalesced-press counter
  always_comb begin
    if (drop_sum_s > 9'd255) begin
      drop_cnt_d = 8'hFF;
    end else begin
      drop_cnt_d = drop_sum_s[7:0];
    end
  end

  // Drop counter register; only reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ev.ev_valid  = (state_q == SLOT_FULL);
  assign ev.ev_player = ev_player_q;
  assign ev.ev_button = ev_button_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
